// File: rtl/mips_defs_pkg.sv
// Shared definitions for fetch and decode: fetch FSM encoding, reset PC
// and the instruction-register field bit positions.
package mips_defs_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int SHAMT_HI = 10;
   localparam int SHAMT_LO = 6;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int J_HI     = 25;
   localparam int J_LO     = 0;

endpackage

// File: rtl/ir_field_split.sv
// Combinational split of an instruction word into its decode fields;
// also instantiated by the decode stage.
module ir_field_split
   import mips_defs_pkg::*;
(
   input  logic [31:0] ir,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] imm26
);

   assign op    = ir[OP_HI:OP_LO];
   assign rs    = ir[RS_HI:RS_LO];
   assign rt    = ir[RT_HI:RT_LO];
   assign rd    = ir[RD_HI:RD_LO];
   assign shamt = ir[SHAMT_HI:SHAMT_LO];
   assign funct = ir[FUNCT_HI:FUNCT_LO];
   assign imm16 = ir[IMM_HI:IMM_LO];
   assign imm26 = ir[J_HI:J_LO];

endmodule

// File: rtl/instr_fetch_ir.sv
// Multi-cycle instruction fetch: PC, req/ack fetch FSM and instruction register.
// Optional misaligned-fetch check enabled by defining FETCH_ALIGN_CHK_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no fetch outstanding; pc_we and fetch_start honoured
// ST_REQ  | imem_req held at the latched address until imem_ack
module instr_fetch_ir
   import mips_defs_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic        pc_we,
   input  logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        busy,
   output logic        ir_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] imm26,
   output logic        fetch_err
);

   fetch_state_t state;
   logic [31:0]  pc_q;
   logic [31:0]  ir_q;
   logic [31:0]  addr_q;
   logic         req_q;
   logic         ir_valid_q;
   logic         misaligned;

`ifdef FETCH_ALIGN_CHK_EN
   logic err_q;
   assign misaligned = (pc_q[1:0] != 2'b00);
   assign fetch_err  = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else if (state == ST_IDLE && fetch_start && misaligned)
         err_q <= 1'b1;
   end
`else
   assign misaligned = 1'b0;
   assign fetch_err  = 1'b0;
`endif

   // The fetch address is captured at the start edge, so a simultaneous
   // pc_we moves the PC without disturbing the request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         ir_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pc_we)
                  pc_q <= pc_next;
               if (fetch_start && !misaligned) begin
                  state      <= ST_REQ;
                  addr_q     <= pc_q;
                  req_q      <= 1'b1;
                  ir_valid_q <= 1'b0;
               end
            end
            ST_REQ: begin
               if (imem_ack) begin
                  state      <= ST_IDLE;
                  ir_q       <= imem_rdata;
                  req_q      <= 1'b0;
                  ir_valid_q <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = req_q;
   assign busy      = req_q;
   assign imem_addr = addr_q;
   assign ir_valid  = ir_valid_q;
   assign pc        = pc_q;
   assign pc_plus4  = pc_q + 32'd4;
   assign instr     = ir_q;

   ir_field_split u_split (
      .ir    (ir_q),
      .op    (op),
      .rs    (rs),
      .rt    (rt),
      .rd    (rd),
      .shamt (shamt),
      .funct (funct),
      .imm16 (imm16),
      .imm26 (imm26)
   );

endmodule

// File: tb/tb_instr_fetch_ir.sv
// Directed bench for instr_fetch_ir; inputs change 1 ns after the rising
// edge and outputs are checked there, away from the active edge.
module tb_instr_fetch_ir;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic        pc_we;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        busy;
   logic        ir_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic        fetch_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch_ir dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .pc_we       (pc_we),
      .pc_next     (pc_next),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .busy        (busy),
      .ir_valid    (ir_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr       (instr),
      .op          (op),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .funct       (funct),
      .imm16       (imm16),
      .imm26       (imm26),
      .fetch_err   (fetch_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pc(input logic [31:0] v);
      pc_we = 1'b1; pc_next = v;
      tick();
      pc_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; fetch_start = 1'b0; pc_we = 1'b0; pc_next = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      #2;
      n_checks++;
      if ({imem_req, busy, ir_valid, fetch_err} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000", {imem_req, busy, ir_valid, fetch_err});
      end
      n_checks++;
      if (pc !== 32'h0000_3000) begin
         n_fail++; $display("FAIL reset_pc: got %h expected 00003000", pc);
      end
      n_checks++;
      if (instr !== 32'h0) begin
         n_fail++; $display("FAIL reset_ir: got %h expected 0", instr);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_fetch();
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({imem_req, busy} !== 2'b11 || imem_addr !== 32'h0000_3000) begin
            n_fail++; $display("FAIL fetch_req_%0d: req=%b busy=%b addr=%h expected 1 1 00003000", i, imem_req, busy, imem_addr);
         end
         n_checks++;
         if (ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL fetch_valid_early_%0d: got %b expected 0", i, ir_valid);
         end
         if (i < 2) tick();
      end
      imem_ack = 1'b1; imem_rdata = 32'h2009_FFFF;
      tick();
      imem_ack = 1'b0; imem_rdata = '0;
      n_checks++;
      if ({imem_req, busy, ir_valid} !== 3'b001) begin
         n_fail++; $display("FAIL fetch_done: req/busy/valid=%b expected 001", {imem_req, busy, ir_valid});
      end
      n_checks++;
      if (instr !== 32'h2009_FFFF || op !== 6'h08 || rt !== 5'd9 || imm16 !== 16'hFFFF) begin
         n_fail++; $display("FAIL fetch_fields: instr=%h op=%h rt=%0d imm16=%h expected 2009ffff 08 9 ffff", instr, op, rt, imm16);
      end
      n_checks++;
      if (rs !== 5'd0 || rd !== 5'h1F || shamt !== 5'h1F || funct !== 6'h3F || imm26 !== 26'h009_FFFF) begin
         n_fail++; $display("FAIL fetch_slices: rs=%h rd=%h shamt=%h funct=%h imm26=%h expected 00 1f 1f 3f 009ffff", rs, rd, shamt, funct, imm26);
      end
   endtask

   task automatic test_pc_update();
      load_pc(32'h0000_3010);
      n_checks++;
      if (pc !== 32'h0000_3010 || pc_plus4 !== 32'h0000_3014) begin
         n_fail++; $display("FAIL pc_load: pc=%h plus4=%h expected 00003010 00003014", pc, pc_plus4);
      end
      load_pc(32'hFFFF_FFFC);
      n_checks++;
      if (pc_plus4 !== 32'h0000_0000) begin
         n_fail++; $display("FAIL pc_wrap: got %h expected 00000000", pc_plus4);
      end
      load_pc(32'h0000_3000);
   endtask

   task automatic test_busy_ignores();
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b1; pc_we = 1'b1; pc_next = 32'h0000_4000;
      tick();
      fetch_start = 1'b0; pc_we = 1'b0;
      n_checks++;
      if (pc !== 32'h0000_3000 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
         n_fail++; $display("FAIL busy_pc: pc=%h req=%b addr=%h expected 00003000 1 00003000", pc, imem_req, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
      tick();
      imem_ack = 1'b0;
      n_checks++;
      if (instr !== 32'h8C22_0004 || ir_valid !== 1'b1) begin
         n_fail++; $display("FAIL busy_word: instr=%h valid=%b expected 8c220004 1", instr, ir_valid);
      end
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL single_req_%0d: req=%b expected 0", i, imem_req);
         end
      end
      // Stray ack while idle must not touch IR.
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_checks++;
      if (instr !== 32'h8C22_0004 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL idle_ack: instr=%h req=%b expected 8c220004 0", instr, imem_req);
      end
   endtask

   task automatic test_reset_mid_req();
      load_pc(32'h0000_3010);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_req: req=%b busy=%b expected 0 0", imem_req, busy);
      end
      n_checks++;
      if (pc !== 32'h0000_3000 || instr !== 32'h0) begin
         n_fail++; $display("FAIL rst_regs: pc=%h instr=%h expected 00003000 0", pc, instr);
      end
      #1;
      rst = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      n_checks++;
      if (instr !== 32'h0 || ir_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL rst_stray_ack: instr=%h valid=%b req=%b expected 0 0 0", instr, ir_valid, imem_req);
      end
   endtask

   task automatic test_pc_we_with_start();
      pc_we = 1'b1; pc_next = 32'h0000_3008; fetch_start = 1'b1;
      tick();
      pc_we = 1'b0; fetch_start = 1'b0;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 || pc !== 32'h0000_3008) begin
         n_fail++; $display("FAIL same_cycle: req=%b addr=%h pc=%h expected 1 00003000 00003008", imem_req, imem_addr, pc);
      end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
      tick();
      imem_ack = 1'b0;
      n_checks++;
      if (instr !== 32'h0000_0020 || funct !== 6'h20 || pc !== 32'h0000_3008) begin
         n_fail++; $display("FAIL same_cycle_done: instr=%h funct=%h pc=%h expected 00000020 20 00003008", instr, funct, pc);
      end
   endtask

   task automatic test_misaligned();
      load_pc(32'h0000_3002);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL align_err_%0d: err=%b req=%b expected 1 0", i, fetch_err, imem_req);
         end
         tick();
      end
`else
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3002 || fetch_err !== 1'b0) begin
         n_fail++; $display("FAIL unaligned_req: req=%b addr=%h err=%b expected 1 00003002 0", imem_req, imem_addr, fetch_err);
      end
      imem_ack = 1'b1; imem_rdata = 32'hA5A5_0001;
      tick();
      imem_ack = 1'b0;
      n_checks++;
      if (instr !== 32'hA5A5_0001 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL unaligned_done: instr=%h req=%b expected a5a50001 0", instr, imem_req);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_pc_update();
      test_busy_ignores();
      test_reset_mid_req();
      test_pc_we_with_start();
      test_misaligned();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
